// File: rtl/tri_idle_seq.sv
// Idle-qualified power-gating sequencer: per-lane idle counters feed a
// RUN -> REQ -> GATED -> WAKE handshake FSM that requests and releases gating.
module tri_idle_seq #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 4,
  parameter int THRESH    = 8
) (
  input  logic             nclk,
  input  logic             rst,
  input  logic             act,
  input  logic [0:WIDTH-1] idle_in,
  input  logic             gate_ack,
  input  logic             wake_ack,
  output logic [0:WIDTH-1] idle_q,
  output logic             gate_req,
  output logic             gated,
  output logic             wake_req,
  output logic [1:0]       state_dbg
);

  // Handshake: gate_req stays high until gate_ack is sampled in REQ (or a lane
  // goes busy first, aborting); wake_req stays high until wake_ack is sampled
  // in WAKE. Acks are only sampled on edges with act=1 in the matching state.
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REQ   = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] THRESH_C = CNT_WIDTH'(THRESH);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];
  logic                 all_idle;
  logic                 any_busy;

  always_ff @(posedge nclk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (act) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!idle_in[i])          cnt[i] <= '0;
        else if (cnt[i] < THRESH_C) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    idle_q = '0;
    for (int i = 0; i < WIDTH; i++) idle_q[i] = (cnt[i] == THRESH_C);
  end

  assign all_idle = &idle_q;
  assign any_busy = ~&idle_in;

  always_ff @(posedge nclk) begin
    if (rst)      state_q <= S_RUN;
    else if (act) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (all_idle) state_d = S_REQ;
      // A coincident ack wins over an abort.
      S_REQ: begin
        if (gate_ack)      state_d = S_GATED;
        else if (any_busy) state_d = S_RUN;
      end
      S_GATED: if (any_busy) state_d = S_WAKE;
      S_WAKE:  if (wake_ack) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign gate_req  = (state_q == S_REQ);
  assign gated     = (state_q == S_GATED);
  assign wake_req  = (state_q == S_WAKE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tri_idle_seq.sv
// Directed bench for tri_idle_seq (WIDTH=2, CNT_WIDTH=2, THRESH=3).
module tb_tri_idle_seq;

  localparam logic [1:0] RUN = 2'd0, REQ = 2'd1, GATED = 2'd2, WAKE = 2'd3;

  logic       nclk = 1'b0;
  logic       rst = 1'b1;
  logic       act = 1'b0;
  logic [0:1] idle_in = 2'b00;
  logic       gate_ack = 1'b0;
  logic       wake_ack = 1'b0;
  logic [0:1] idle_q;
  logic       gate_req, gated, wake_req;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  tri_idle_seq #(.WIDTH(2), .CNT_WIDTH(2), .THRESH(3)) dut (
    .nclk(nclk), .rst(rst), .act(act), .idle_in(idle_in),
    .gate_ack(gate_ack), .wake_ack(wake_ack), .idle_q(idle_q),
    .gate_req(gate_req), .gated(gated), .wake_req(wake_req),
    .state_dbg(state_dbg)
  );

  always #5 nclk = ~nclk;

  task automatic step();
    @(posedge nclk);
    #1;
  endtask

  // Compares {idle_q[0], idle_q[1], gate_req, gated, wake_req, state}.
  task automatic chk(input string tag, input logic [1:0] e_idle, input logic e_gr,
                     input logic e_g, input logic e_wr, input logic [1:0] e_st);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {idle_q, gate_req, gated, wake_req, state_dbg};
    exp = {e_idle, e_gr, e_g, e_wr, e_st};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; act = 1'b1; idle_in = 2'b00; gate_ack = 1'b0; wake_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset", 2'b00, 0, 0, 0, RUN);

    // Basic qualification, latency and gate handshake
    idle_in = 2'b11;
    step(); chk("e1", 2'b00, 0, 0, 0, RUN);
    step(); chk("e2", 2'b00, 0, 0, 0, RUN);
    step(); chk("e3_idle_q", 2'b11, 0, 0, 0, RUN);
    step(); chk("e4_gate_req", 2'b11, 1, 0, 0, REQ);
    step(); chk("e5_hold_req", 2'b11, 1, 0, 0, REQ);
    gate_ack = 1'b1;
    step(); chk("e6_gated", 2'b11, 0, 1, 0, GATED);
    gate_ack = 1'b0;
    step(); chk("gated_hold", 2'b11, 0, 1, 0, GATED);

    // Wake handshake with delayed ack; stray gate_ack ignored in WAKE
    idle_in = 2'b01;
    step(); chk("wake_n", 2'b01, 0, 0, 1, WAKE);
    idle_in = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      gate_ack = (i == 2);
      step();
      chk("wake_hold", (i >= 3) ? 2'b11 : 2'b01, 0, 0, 1, WAKE);
    end
    gate_ack = 1'b0;
    wake_ack = 1'b1;
    step(); chk("wake_ack_run", 2'b11, 0, 0, 0, RUN);
    wake_ack = 1'b0;
    step(); chk("rerequest", 2'b11, 1, 0, 0, REQ);

    // Ack together with busy in REQ: ack wins, then WAKE
    gate_ack = 1'b1; idle_in = 2'b01;
    step(); chk("ack_wins", 2'b01, 0, 1, 0, GATED);
    gate_ack = 1'b0;
    step(); chk("then_wake", 2'b01, 0, 0, 1, WAKE);
    idle_in = 2'b11; wake_ack = 1'b1;
    step(); chk("wake_done", 2'b01, 0, 0, 0, RUN);
    wake_ack = 1'b0;

    // Abort from REQ on a one-cycle busy lane; acks ignored in RUN
    do_reset();
    idle_in = 2'b11;
    repeat (4) step();
    chk("abort_setup", 2'b11, 1, 0, 0, REQ);
    idle_in = 2'b10;
    step(); chk("abort_run", 2'b10, 0, 0, 0, RUN);
    idle_in = 2'b11; gate_ack = 1'b1; wake_ack = 1'b1;
    step(); chk("abort_e6", 2'b10, 0, 0, 0, RUN);
    step(); chk("abort_e7", 2'b10, 0, 0, 0, RUN);
    step(); chk("abort_e8", 2'b11, 0, 0, 0, RUN);
    gate_ack = 1'b0; wake_ack = 1'b0;
    step(); chk("abort_e9_req", 2'b11, 1, 0, 0, REQ);

    // Saturation: 2-bit counter must not wrap past 3
    do_reset();
    idle_in = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("saturate", (i >= 3) ? 2'b11 : 2'b00, (i >= 4), 0, 0, (i >= 4) ? REQ : RUN);
    end

    // act=0: everything holds, acks ignored
    act = 1'b0; gate_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_in = (i % 2 == 0) ? 2'b00 : 2'b01;
      step();
      chk("act0_hold", 2'b11, 1, 0, 0, REQ);
    end
    act = 1'b1; idle_in = 2'b11;
    step(); chk("act1_gated", 2'b11, 0, 1, 0, GATED);
    gate_ack = 1'b0;

    // Reset in GATED (with act=0): drops everything at that edge
    rst = 1'b1; act = 1'b0;
    step(); chk("rst_gated", 2'b00, 0, 0, 0, RUN);
    rst = 1'b0; act = 1'b1;
    step(); chk("post_rst", 2'b00, 0, 0, 0, RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
